// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared widths, index type and the constant
// pattern table used by the sequence generator.
package seq_gen_pkg;

   localparam int DATA_W = 4;
   localparam int SEQ_LEN = 8;
   localparam int IDX_W = $clog2(SEQ_LEN);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam data_t SEQ_TABLE [0:SEQ_LEN-1] = '{
      4'hA, 4'hB, 4'hE, 4'h7,
      4'hF, 4'h2, 4'h0, 4'hD
   };

endpackage

// File: rtl/seq_gen_rom.sv
// seq_gen_rom: combinational index -> pattern value lookup.
// Ports: index (in, idx_t), value (out, data_t).
module seq_gen_rom
   import seq_gen_pkg::*;
(
   input  idx_t  index,
   output data_t value
);

   assign value = SEQ_TABLE[index];

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: free-running 4-bit cyclic pattern source.
// Ports: clk, reset_n (async low), enable (advance), data (registered).
module sequence_generator
   import seq_gen_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [DATA_W-1:0] data
);

   idx_t  index;
   data_t rom_value;

   seq_gen_rom u_rom (
      .index (index),
      .value (rom_value)
   );

   // index points at the next element; it wraps 7 -> 0 by overflow
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index <= '0;
         data  <= '0;
      end else if (enable) begin
         index <= index + idx_t'(1);
         data  <= rom_value;
      end
   end

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed stimulus with a queue-based
// scoreboard; a monitor pops and compares after each clock edge.
module tb_sequence_generator;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic [3:0] data;

   int checks;
   int failures;
   logic [3:0] exp_q [$];
   event chk_now;

   sequence_generator dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .data    (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: the output is presented after every edge (or after an
   // asynchronous event flagged by chk_now); compare against queue head
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk or chk_now);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (data !== e) begin
               failures++;
               $display("FAIL data t=%0t got=%h exp=%h", $time, data, e);
            end
         end
      end
   end

   // drive inputs at the falling edge; expect value after next rise
   task automatic cyc(input logic en, input logic rst, input logic [3:0] e);
      @(negedge clk);
      enable  = en;
      reset_n = rst;
      exp_q.push_back(e);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 1'b0;
      enable  = 1'b0;

      // reset state
      #1;
      exp_q.push_back(4'h0);
      ->chk_now;
      cyc(1'b0, 1'b0, 4'h0);
      cyc(1'b0, 1'b0, 4'h0);
      cyc(1'b0, 1'b1, 4'h0);

      // full sequence plus wrap
      cyc(1'b1, 1'b1, 4'hA);
      cyc(1'b1, 1'b1, 4'hB);
      cyc(1'b1, 1'b1, 4'hE);
      cyc(1'b1, 1'b1, 4'h7);
      cyc(1'b1, 1'b1, 4'hF);
      cyc(1'b1, 1'b1, 4'h2);
      cyc(1'b1, 1'b1, 4'h0);
      cyc(1'b1, 1'b1, 4'hD);
      cyc(1'b1, 1'b1, 4'hA);
      cyc(1'b1, 1'b1, 4'hB);

      // restart, then enable gap
      cyc(1'b0, 1'b0, 4'h0);
      cyc(1'b1, 1'b1, 4'hA);
      cyc(1'b1, 1'b1, 4'hB);
      cyc(1'b1, 1'b1, 4'hE);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b1, 4'hE);
      cyc(1'b1, 1'b1, 4'h7);
      cyc(1'b1, 1'b1, 4'hF);

      // async reset between edges: data clears before next rise
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      exp_q.push_back(4'h0);
      ->chk_now;
      cyc(1'b1, 1'b1, 4'hA);
      cyc(1'b1, 1'b1, 4'hB);

      // enable held through reset
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b1, 4'hA);
      cyc(1'b1, 1'b1, 4'hB);
      cyc(1'b1, 1'b1, 4'hE);

      // drain: every expectation must have been consumed
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
